hwpe_stream_zero_fifo: RTL and testbench

Data-less FIFO for the zero network: stores only the strobe of each beat and reproduces the exact handshake timing of the normal-path stream FIFO. It sits in front of the zero sink (drives its `zero_i`), mirroring the FIFO on the normal path. Any divergence in valid/strb sequencing between the two paths becomes visible at the sink as a fault. Data is never stored, so storage area is STRB_WIDTH/(DATA_WIDTH+STRB_WIDTH) of the normal FIFO.

---
 rtl/hwpe_stream_zero_fifo_if.sv | 14 +
 rtl/hwpe_stream_zero_fifo.sv | 74 +++++++
 tb/tb_hwpe_stream_zero_fifo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_zero_fifo_if.sv
// Purpose: valid/ready stream bundle (data + byte strobe) shared by the zero and normal paths.
// Latency: none; pure wiring.
// Backpressure: ready flows from sink to source; a beat transfers when valid && ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_zero_fifo.sv
// Purpose: data-less FIFO for the zero network; stores only strobes, mirrors the normal-path FIFO handshakes.
// Latency: a beat pushed at edge N is visible on pop_o from cycle N+1 (no fall-through).
// Backpressure: push_i.ready = !full, pop_o.valid = !empty, both from registered state only.
//
// Ports:
//   clk_i    - clock, all state on rising edge
//   clear_i  - synchronous active-high clear; wins over push/pop in the same cycle
//   push_i   - zero-stream input (sink); data ignored, strb stored
//   pop_o    - zero-stream output (source); data tied to zero
//   empty_o  - no entries stored
//   full_o   - FIFO_DEPTH entries stored
//   count_o  - occupancy 0..FIFO_DEPTH
module hwpe_stream_zero_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        clear_i,
  hwpe_stream_intf_stream.sink        push_i,
  hwpe_stream_intf_stream.source      pop_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [STRB_WIDTH-1:0] strb_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;

  logic push_fire;
  logic pop_fire;

  // Payload is intentionally dropped on this path.
  logic unused_data;
  assign unused_data = ^push_i.data;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == DEPTH_CNT);
  assign count_o = cnt;

  assign push_i.ready = !full_o;
  assign pop_o.valid  = !empty_o;
  assign pop_o.strb   = strb_mem[rd_ptr];
  assign pop_o.data   = '0;

  assign push_fire = push_i.valid && !full_o;
  assign pop_fire  = pop_o.ready && !empty_o;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)      cnt <= cnt + 1'b1;
      else if (pop_fire && !push_fire) cnt <= cnt - 1'b1;
    end
  end

  // Storage is not cleared; a push coinciding with clear is discarded.
  always_ff @(posedge clk_i) begin
    if (push_fire && !clear_i) strb_mem[wr_ptr] <= push_i.strb;
  end

endmodule

// File: tb/tb_hwpe_stream_zero_fifo.sv
module tb_hwpe_stream_zero_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       clear;
  logic       empty;
  logic       full;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: plain queue of stored strobes.
  logic [3:0] mq[$];

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

  hwpe_stream_zero_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .clear_i (clear),
    .push_i  (push_if),
    .pop_o   (pop_if),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and apply the FIFO rules to the model queue.
  task automatic tick();
    bit         pf;
    bit         qf;
    logic [3:0] s;
    pf = push_if.valid && (mq.size() < DEPTH);
    qf = pop_if.ready && (mq.size() > 0);
    s  = push_if.strb;
    @(posedge clk);
    if (clear) begin
      mq.delete();
    end else begin
      if (qf) void'(mq.pop_front());
      if (pf) mq.push_back(s);
    end
    #1;
  endtask

  task automatic idle();
    push_if.valid = 1'b0;
    push_if.strb  = '0;
    push_if.data  = '0;
    pop_if.ready  = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    idle();
    tick();
    tick();
    clear = 1'b0;
    total++; if (pop_if.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pop_if.valid); end
    total++; if (push_if.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", push_if.ready); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (pop_if.data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", pop_if.data); end
  endtask

  task automatic test_fill_drain();
    idle();
    for (int i = 1; i <= DEPTH; i++) begin
      push_if.valid = 1'b1;
      push_if.strb  = 4'(i);
      tick();
      total++; if (count !== 4'(i)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, i); end
    end
    push_if.valid = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
    total++; if (push_if.ready !== 1'b0) begin bad++; $display("FAIL fill_ready: got %b want 0", push_if.ready); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count8: got %0d want 8", count); end
    pop_if.ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      total++; if (pop_if.valid !== 1'b1) begin bad++; $display("FAIL drain_valid: got %b want 1", pop_if.valid); end
      total++; if (pop_if.strb !== 4'(i)) begin bad++; $display("FAIL drain_order: got %h want %h", pop_if.strb, 4'(i)); end
      tick();
    end
    pop_if.ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_simultaneous();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      push_if.valid = 1'b1;
      push_if.strb  = 4'(i + 3);
      tick();
    end
    // Full: push refused, pop fires.
    push_if.strb = 4'hA;
    pop_if.ready = 1'b1;
    total++; if (push_if.ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", push_if.ready); end
    tick();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_pop_count: got %0d want 7", count); end
    total++; if (push_if.ready !== 1'b1) begin bad++; $display("FAIL full_ready_rise: got %b want 1", push_if.ready); end
    tick();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL push_pop7_count: got %0d want 7", count); end
    push_if.valid = 1'b0;
    for (int guard = 0; guard < 20 && mq.size() > 0; guard++) begin
      total++; if (pop_if.strb !== mq[0]) begin bad++; $display("FAIL sim_drain: got %h want %h", pop_if.strb, mq[0]); end
      tick();
    end
    // Partial occupancy: push and pop together keep count.
    pop_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_if.valid = 1'b1;
      push_if.strb  = 4'(i + 1);
      tick();
    end
    push_if.strb = 4'hC;
    pop_if.ready = 1'b1;
    tick();
    total++; if (count !== 4'd3) begin bad++; $display("FAIL mid_push_pop_count: got %0d want 3", count); end
    total++; if (pop_if.strb !== 4'h2) begin bad++; $display("FAIL mid_push_pop_head: got %h want 2", pop_if.strb); end
    push_if.valid = 1'b0;
    for (int guard = 0; guard < 20 && mq.size() > 0; guard++) begin
      total++; if (pop_if.strb !== mq[0]) begin bad++; $display("FAIL mid_drain: got %h want %h", pop_if.strb, mq[0]); end
      tick();
    end
    pop_if.ready = 1'b0;
  endtask

  task automatic test_latency();
    idle();
    push_if.valid = 1'b1;
    push_if.data  = 32'hDEADBEEF;
    push_if.strb  = 4'hF;
    total++; if (pop_if.valid !== 1'b0) begin bad++; $display("FAIL lat_no_fallthrough: got %b want 0", pop_if.valid); end
    tick();
    idle();
    total++; if (pop_if.valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want 1", pop_if.valid); end
    total++; if (pop_if.strb !== 4'hF) begin bad++; $display("FAIL lat_strb: got %h want f", pop_if.strb); end
    total++; if (pop_if.data !== 32'h0) begin bad++; $display("FAIL lat_data: got %h want 0", pop_if.data); end
    pop_if.ready = 1'b1;
    tick();
    pop_if.ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL lat_empty: got %b want 1", empty); end
  endtask

  task automatic test_clear();
    idle();
    for (int i = 0; i < 5; i++) begin
      push_if.valid = 1'b1;
      push_if.strb  = 4'(i + 9);
      tick();
    end
    clear = 1'b1;
    push_if.strb = 4'h3;
    tick();
    clear = 1'b0;
    push_if.valid = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL clr_empty: got %b want 1", empty); end
    total++; if (pop_if.valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", pop_if.valid); end
    push_if.valid = 1'b1;
    push_if.strb  = 4'h6;
    tick();
    push_if.valid = 1'b0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL clr_after_count: got %0d want 1", count); end
    total++; if (pop_if.strb !== 4'h6) begin bad++; $display("FAIL clr_after_strb: got %h want 6", pop_if.strb); end
    pop_if.ready = 1'b1;
    tick();
    pop_if.ready = 1'b0;
  endtask

  task automatic test_wrap_random();
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    idle();
    while (recv < 20 && cyc < 500) begin
      push_if.valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      push_if.strb  = 4'(sent);
      pop_if.ready  = ($urandom_range(0, 3) != 0);
      total++; if (count !== 4'(mq.size())) begin bad++; $display("FAIL wrap_count: got %0d want %0d", count, mq.size()); end
      total++; if (count > 4'd8) begin bad++; $display("FAIL wrap_overflow: got %0d want <=8", count); end
      total++; if (push_if.ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL wrap_ready: got %b want %b", push_if.ready, mq.size() < DEPTH); end
      total++; if (pop_if.valid !== (mq.size() > 0)) begin bad++; $display("FAIL wrap_valid: got %b want %b", pop_if.valid, mq.size() > 0); end
      if (mq.size() > 0 && pop_if.ready) begin
        total++; if (pop_if.strb !== 4'(recv)) begin bad++; $display("FAIL wrap_order: got %h want %h", pop_if.strb, 4'(recv)); end
        recv++;
      end
      if (push_if.valid && mq.size() < DEPTH) sent++;
      tick();
      cyc++;
    end
    total++; if (recv != 20) begin bad++; $display("FAIL wrap_timeout: got %0d beats want 20", recv); end
    idle();
  endtask

  initial begin
    clear = 1'b1;
    idle();
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_latency();
    test_clear();
    test_wrap_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
